// File: rtl/dsp_tx_burst_ctrl.sv
// Per-channel TX burst sequencer: arms from the settings bus, optionally waits for a
// VITA time, streams FIFO samples into the DUC on its strobes, then drains with zeros.
module dsp_tx_burst_ctrl #(
    parameter int BASE         = 0,
    parameter int DRAIN_CYCLES = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic [63:0] vita_time,
    input  logic [31:0] in_data,
    input  logic        in_eob,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] duc_in_sample,
    input  logic        duc_in_strobe,
    output logic        duc_in_enable,
    output logic        busy,
    output logic        underflow,
    output logic        late,
    output logic        cmd_overrun,
    output logic [31:0] debug
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_RUN     = 3'd2,
        S_DRAIN   = 3'd3,
        S_DISCARD = 3'd4
    } state_t;

    localparam logic [7:0] ADDR_TIME_HI = 8'(BASE);
    localparam logic [7:0] ADDR_TIME_LO = 8'(BASE + 1);
    localparam logic [7:0] ADDR_CTRL    = 8'(BASE + 2);
    localparam logic [7:0] DRAIN_LOAD   = 8'(DRAIN_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_time_hi;
    logic [15:0] r_len;
    logic        r_timed;
    // Copies taken at arm time so later settings writes only affect the next command.
    logic [63:0] r_act_time;
    logic [15:0] r_act_len;
    logic [15:0] r_sample_count;
    logic [7:0]  r_drain_cnt;
    logic        r_wait_first;
    logic        r_uf_burst;
    logic        r_eob_seen;
    logic        r_underflow;
    logic        r_late;
    logic        r_cmd_overrun;

    logic w_busy;
    logic w_arm;
    logic w_pop;
    logic w_starve;
    logic w_end;
    logic w_late;
    logic w_unused_ctrl;

    assign w_busy        = (r_state != S_IDLE);
    assign w_arm         = set_stb && (set_addr == ADDR_TIME_LO);
    assign w_pop         = (r_state == S_RUN) && duc_in_strobe && in_valid;
    assign w_starve      = (r_state == S_RUN) && duc_in_strobe && !in_valid;
    assign w_end         = in_eob || ((r_act_len != 16'd0) && ((r_sample_count + 16'd1) == r_act_len));
    assign w_late        = r_wait_first && (vita_time > r_act_time);
    assign w_unused_ctrl = ^set_data[30:16];

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (clear) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (w_arm) w_next = r_timed ? S_WAIT : S_RUN;
                S_WAIT: begin
                    if (w_late) w_next = S_IDLE;
                    else if (vita_time == r_act_time) w_next = S_RUN;
                end
                S_RUN:     if ((w_pop && w_end) || w_starve) w_next = S_DRAIN;
                S_DRAIN: begin
                    if (r_drain_cnt == 8'd0) w_next = (r_uf_burst && !r_eob_seen) ? S_DISCARD : S_IDLE;
                end
                S_DISCARD: if (in_valid && in_eob) w_next = S_IDLE;
                default:   w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_time_hi      <= '0;
            r_len          <= '0;
            r_timed        <= 1'b0;
            r_act_time     <= '0;
            r_act_len      <= '0;
            r_sample_count <= '0;
            r_drain_cnt    <= '0;
            r_wait_first   <= 1'b0;
            r_uf_burst     <= 1'b0;
            r_eob_seen     <= 1'b0;
            r_underflow    <= 1'b0;
            r_late         <= 1'b0;
            r_cmd_overrun  <= 1'b0;
        end else begin
            if (set_stb && set_addr == ADDR_TIME_HI) r_time_hi <= set_data;
            if (set_stb && set_addr == ADDR_CTRL) begin
                r_len   <= set_data[15:0];
                r_timed <= set_data[31];
            end
            if (clear) begin
                r_drain_cnt   <= '0;
                r_wait_first  <= 1'b0;
                r_underflow   <= 1'b0;
                r_late        <= 1'b0;
                r_cmd_overrun <= 1'b0;
            end else begin
                if (w_arm && w_busy) r_cmd_overrun <= 1'b1;
                case (r_state)
                    S_IDLE: begin
                        if (w_arm) begin
                            r_act_time     <= {r_time_hi, set_data};
                            r_act_len      <= r_len;
                            r_sample_count <= '0;
                            r_wait_first   <= 1'b1;
                            r_uf_burst     <= 1'b0;
                            r_eob_seen     <= 1'b0;
                        end
                    end
                    S_WAIT: begin
                        r_wait_first <= 1'b0;
                        if (w_late) r_late <= 1'b1;
                    end
                    S_RUN: begin
                        if (w_pop) begin
                            r_sample_count <= r_sample_count + 16'd1;
                            if (in_eob) r_eob_seen <= 1'b1;
                            if (w_end) r_drain_cnt <= DRAIN_LOAD;
                        end else if (w_starve) begin
                            r_underflow <= 1'b1;
                            r_uf_burst  <= 1'b1;
                            r_drain_cnt <= DRAIN_LOAD;
                        end
                    end
                    S_DRAIN: begin
                        if (r_drain_cnt != 8'd0) r_drain_cnt <= r_drain_cnt - 8'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        duc_in_enable = 1'b0;
        duc_in_sample = '0;
        in_ready      = 1'b0;
        case (r_state)
            S_RUN: begin
                duc_in_enable = 1'b1;
                duc_in_sample = in_valid ? in_data : 32'd0;
                in_ready      = duc_in_strobe & in_valid;
            end
            S_DRAIN:   duc_in_enable = 1'b1;
            S_DISCARD: in_ready = 1'b1;
            default: ;
        endcase
    end

    assign busy        = w_busy;
    assign underflow   = r_underflow;
    assign late        = r_late;
    assign cmd_overrun = r_cmd_overrun;
    assign debug       = {r_state, 13'b0, r_sample_count};
endmodule

// File: tb/tb_dsp_tx_burst_ctrl.sv
// Directed bench for dsp_tx_burst_ctrl: a queue-backed FIFO model feeds the DUT and
// each check is an immediate assertion against hand-derived values.
module tb_dsp_tx_burst_ctrl;
  logic        clock = 1'b0;
  logic        reset;
  logic        clear;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [63:0] vita_time;
  logic [31:0] in_data;
  logic        in_eob;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] duc_in_sample;
  logic        duc_in_strobe;
  logic        duc_in_enable;
  logic        busy;
  logic        underflow;
  logic        late;
  logic        cmd_overrun;
  logic [31:0] debug;

  dsp_tx_burst_ctrl #(.BASE(0), .DRAIN_CYCLES(32)) dut (
    .clock(clock), .reset(reset), .clear(clear),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .vita_time(vita_time),
    .in_data(in_data), .in_eob(in_eob), .in_valid(in_valid), .in_ready(in_ready),
    .duc_in_sample(duc_in_sample), .duc_in_strobe(duc_in_strobe), .duc_in_enable(duc_in_enable),
    .busy(busy), .underflow(underflow), .late(late), .cmd_overrun(cmd_overrun), .debug(debug)
  );

  // clock / reset
  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  logic [32:0] fifo_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] duc_q[$];
  int pop_cnt = 0;
  int cyc_n = 0;
  int strobe_mode = 0;
  logic vita_inc = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    in_valid = (fifo_q.size() != 0);
    if (in_valid) {in_eob, in_data} = fifo_q[0];
    else begin
      in_eob  = 1'b0;
      in_data = 32'hDEAD_BEEF;
    end
  endtask

  // Account this cycle's handshakes, then move to the next cycle and present new inputs.
  task automatic step();
    if (in_valid && in_ready) begin
      void'(fifo_q.pop_front());
      pop_cnt++;
    end
    if (duc_in_strobe && duc_in_enable) duc_q.push_back(duc_in_sample);
    @(negedge clock);
    cyc_n++;
    if (vita_inc) vita_time = vita_time + 64'd1;
    duc_in_strobe = (strobe_mode == 1) || (strobe_mode == 2 && (cyc_n % 2) == 1);
    drive_fifo();
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] data);
    set_stb  = 1'b1;
    set_addr = addr;
    set_data = data;
    step();
    set_stb  = 1'b0;
  endtask

  task automatic load(input int n, input int eob_idx, input logic [15:0] tag);
    fifo_q.delete();
    for (int k = 0; k < n; k++) fifo_q.push_back({(k == eob_idx), tag, 16'(k)});
    pop_cnt = 0;
  endtask

  initial begin
    int good;
    int early;
    logic seen;

    reset = 1'b0; clear = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
    vita_time = '0; duc_in_strobe = 1'b0; in_valid = 1'b0; in_eob = 1'b0; in_data = '0;
    steps(3);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_sample", duc_in_sample, 0);
    chk("rst_enable", duc_in_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {underflow, late, cmd_overrun}, 0);
    chk("rst_debug", debug, 0);
    reset = 1'b1;
    step();

    // Immediate burst of 4 with strobe every other clock
    fifo_q.delete(); exp_q.delete(); duc_q.delete(); pop_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      fifo_q.push_back({1'b0, 16'(2 * k + 1), 16'(2 * k + 2)});
      if (k < 4) exp_q.push_back({16'(2 * k + 1), 16'(2 * k + 2)});
    end
    strobe_mode = 2;
    wr(8'd2, 32'd4);
    wr(8'd1, 32'd0);
    chk("imm_busy", busy, 1);
    chk("imm_enable", duc_in_enable, 1);
    chk("imm_state_run", debug[31:29], 3'd2);
    chk("imm_sample_zero_latency", duc_in_sample, 32'h00010002);
    for (int i = 0; i < 20 && pop_cnt < 4; i++) step();
    chk("imm_state_drain", debug[31:29], 3'd3);
    good = 0;
    for (int i = 0; i < 32; i++) begin
      if (busy === 1'b1 && duc_in_enable === 1'b1 && duc_in_sample === 32'd0 && in_ready === 1'b0) good++;
      step();
    end
    chk("imm_drain_cycles", good, 32);
    chk("imm_busy_after_drain", busy, 0);
    chk("imm_pops", pop_cnt, 4);
    chk("imm_fifo_left", fifo_q.size(), 2);
    for (int k = 0; k < 4; k++) chk("imm_duc_word", duc_q[k], exp_q[k]);
    chk("imm_count", debug, 32'h4);

    // Timed start at 1000 with time counting from 900
    load(3, -1, 16'h00A0);
    strobe_mode = 1;
    wr(8'd0, 32'd0);
    wr(8'd2, 32'h8000_0002);
    vita_time = 64'd900; vita_inc = 1'b1;
    wr(8'd1, 32'd1000);
    chk("tm_state_wait", debug[31:29], 3'd1);
    chk("tm_enable_low", duc_in_enable, 0);
    seen = 1'b0; early = 0;
    for (int i = 0; i < 200; i++) begin
      if (duc_in_enable === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (in_ready !== 1'b0) early++;
      step();
    end
    chk("tm_enable_seen", seen, 1);
    chk("tm_enable_time", vita_time, 64'd1001);
    chk("tm_no_early_ready", early, 0);
    chk("tm_no_early_pop", pop_cnt, 0);
    steps(40);
    vita_inc = 1'b0;
    chk("tm_pops", pop_cnt, 2);
    chk("tm_idle", busy, 0);

    // Late command
    load(1, -1, 16'h00B0);
    vita_time = 64'd600;
    wr(8'd2, 32'h8000_0000);
    wr(8'd1, 32'd500);
    chk("late_not_yet", late, 0);
    chk("late_wait_ready", in_ready, 0);
    step();
    chk("late_flag", late, 1);
    chk("late_idle", busy, 0);
    steps(3);
    chk("late_no_pop", pop_cnt, 0);

    // Underflow after 3 words, then discard to eob
    clear = 1'b1; step(); clear = 1'b0;
    chk("clr_late", late, 0);
    load(3, -1, 16'h00C0);
    wr(8'd2, 32'd0);
    wr(8'd1, 32'd0);
    steps(3);
    chk("uf_sample_zero", duc_in_sample, 0);
    chk("uf_ready_low", in_ready, 0);
    chk("uf_enable", duc_in_enable, 1);
    step();
    chk("uf_flag", underflow, 1);
    chk("uf_state_drain", debug[31:29], 3'd3);
    chk("uf_count", debug[15:0], 16'd3);
    fifo_q.push_back({1'b0, 32'h00C0_0003});
    fifo_q.push_back({1'b1, 32'h00C0_0004});
    steps(32);
    chk("uf_state_discard", debug[31:29], 3'd4);
    chk("uf_discard_enable", duc_in_enable, 0);
    chk("uf_discard_ready", in_ready, 1);
    chk("uf_no_pop_in_drain", pop_cnt, 3);
    step();
    chk("uf_still_discard", debug[31:29], 3'd4);
    step();
    chk("uf_idle", busy, 0);
    chk("uf_pops", pop_cnt, 5);

    // eob on 3rd word ends a length-10 burst
    load(5, 2, 16'h00D0);
    wr(8'd2, 32'd10);
    wr(8'd1, 32'd0);
    steps(3);
    chk("eob_state_drain", debug[31:29], 3'd3);
    chk("eob_count", debug[15:0], 16'd3);
    steps(32);
    chk("eob_idle", busy, 0);
    chk("eob_pops", pop_cnt, 3);
    chk("eob_fifo_left", fifo_q.size(), 2);

    // Arm during RUN is an overrun
    load(4, -1, 16'h00E0);
    strobe_mode = 2;
    wr(8'd2, 32'd3);
    wr(8'd1, 32'd0);
    chk("ovr_clear_before", cmd_overrun, 0);
    wr(8'd1, 32'h55);
    chk("ovr_flag", cmd_overrun, 1);
    chk("ovr_still_run", debug[31:29], 3'd2);
    for (int i = 0; i < 20 && pop_cnt < 3; i++) step();
    chk("ovr_state_drain", debug[31:29], 3'd3);
    chk("ovr_count", debug[15:0], 16'd3);
    steps(32);
    chk("ovr_idle", busy, 0);
    chk("ovr_pops", pop_cnt, 3);

    // clear mid-RUN
    chk("clr_pre_uf", underflow, 1);
    load(4, -1, 16'h00F0);
    strobe_mode = 1;
    wr(8'd2, 32'd0);
    wr(8'd1, 32'd0);
    strobe_mode = 0;
    step();
    clear = 1'b1; step(); clear = 1'b0;
    chk("clr_busy", busy, 0);
    chk("clr_enable", duc_in_enable, 0);
    chk("clr_flags", {underflow, late, cmd_overrun}, 0);
    chk("clr_debug", debug, 32'h1);

    // reset mid-DRAIN clears everything including settings
    load(1, -1, 16'h0100);
    strobe_mode = 1;
    wr(8'd2, 32'd1);
    wr(8'd1, 32'd0);
    steps(6);
    chk("rd_state_drain", debug[31:29], 3'd3);
    reset = 1'b0; step();
    chk("rd_busy", busy, 0);
    chk("rd_enable", duc_in_enable, 0);
    chk("rd_sample", duc_in_sample, 0);
    chk("rd_ready", in_ready, 0);
    chk("rd_debug", debug, 0);
    reset = 1'b1; step();
    load(2, 1, 16'h0110);
    wr(8'd1, 32'd0);
    chk("rd_untimed_run", debug[31:29], 3'd2);
    steps(2);
    chk("rd_len_zero_pops", pop_cnt, 2);
    chk("rd_len_zero_count", debug[15:0], 16'd2);
    steps(32);
    chk("rd_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
